// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
//   Captures one frame of FRAME_LEN windowed samples into a local buffer,
//   streams it to an FFT core over an AXI-stream style handshake, then waits
//   for the peak finder to report the frame result (or gives up after
//   TIMEOUT cycles) before capturing the next frame.
//
// Ports
//   clk_in           system clock
//   rst_in           asynchronous active-low reset
//   enable_in        level, permits frame capture
//   sample_in        sample to capture (WIDTH bits, signed)
//   sample_valid_in  single-cycle sample strobe
//   fft_data_out     sample to FFT
//   fft_valid_out    stream valid
//   fft_last_out     high with the final sample of the frame
//   fft_ready_in     stream ready from FFT
//   peak_valid_in    frame result strobe from the peak finder
//   busy_out         high whenever the sequencer is not idle
//   frame_done_out   one-cycle pulse when a frame result is accepted
//   timeout_out      one-cycle pulse when the result wait expires
//   frame_count_out  completed frames (accepted + timed out), wrapping
//   drop_count_out   (FRAME_SEQ_DROP_CNT_EN only) saturating count of samples
//                    dropped while streaming or waiting for a result
//
// Build option: define FRAME_SEQ_DROP_CNT_EN to add drop_count_out.
module fft_frame_sequencer #(
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             enable_in,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid_in,
  output logic [WIDTH-1:0] fft_data_out,
  output logic             fft_valid_out,
  output logic             fft_last_out,
  input  logic             fft_ready_in,
  input  logic             peak_valid_in,
  output logic             busy_out,
  output logic             frame_done_out,
  output logic             timeout_out,
  output logic [15:0]      frame_count_out
`ifdef FRAME_SEQ_DROP_CNT_EN
  ,
  output logic [15:0]      drop_count_out
`endif
);

  localparam int unsigned AW = $clog2(FRAME_LEN);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [AW-1:0] WR_LAST = AW'(FRAME_LEN - 1);
  localparam logic [AW:0]   RD_LAST = (AW + 1)'(FRAME_LEN - 1);
  localparam logic [AW:0]   RD_END  = (AW + 1)'(FRAME_LEN);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    WAIT_RESULT
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_idx_q, wr_idx_d;
  logic [AW:0]      rd_idx_q, rd_idx_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic [15:0]      count_q, count_d;
  logic             mem_we;

  logic [WIDTH-1:0] mem_q [FRAME_LEN];

`ifdef FRAME_SEQ_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;
`endif

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    timer_d  = timer_q;
    valid_d  = valid_q;
    last_d   = last_q;
    data_d   = data_q;
    done_d   = 1'b0;
    tmo_d    = 1'b0;
    count_d  = count_q;
    mem_we   = 1'b0;
`ifdef FRAME_SEQ_DROP_CNT_EN
    drop_d   = drop_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (enable_in) begin
          state_d  = FILL;
          wr_idx_d = '0;
        end
      end

      FILL: begin
        // Disable takes priority so a sample coinciding with it is discarded.
        if (!enable_in) begin
          state_d = IDLE;
        end else if (sample_valid_in) begin
          mem_we   = 1'b1;
          wr_idx_d = wr_idx_q + 1'b1;
          if (wr_idx_q == WR_LAST) begin
            state_d  = STREAM;
            rd_idx_d = '0;
          end
        end
      end

      STREAM: begin
        // Single output register: refill whenever it is empty or being
        // drained, so a ready-high FFT sees one transfer per cycle.
        if (valid_q && fft_ready_in && last_q) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          data_d  = '0;
          timer_d = '0;
          state_d = WAIT_RESULT;
        end else if ((!valid_q || fft_ready_in) && (rd_idx_q != RD_END)) begin
          valid_d  = 1'b1;
          data_d   = mem_q[rd_idx_q[AW-1:0]];
          last_d   = (rd_idx_q == RD_LAST);
          rd_idx_d = rd_idx_q + 1'b1;
        end
      end

      WAIT_RESULT: begin
        timer_d = timer_q + 1'b1;
        // A peak arriving on the expiry cycle wins over the timeout.
        if (peak_valid_in || (timer_q == TMO_LAST)) begin
          done_d   = peak_valid_in;
          tmo_d    = !peak_valid_in;
          count_d  = count_q + 16'd1;
          wr_idx_d = '0;
          state_d  = enable_in ? FILL : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef FRAME_SEQ_DROP_CNT_EN
    if (sample_valid_in && ((state_q == STREAM) || (state_q == WAIT_RESULT))
        && (drop_q != '1)) begin
      drop_d = drop_q + 16'd1;
    end
`endif
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      timer_q  <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      count_q  <= '0;
`ifdef FRAME_SEQ_DROP_CNT_EN
      drop_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      timer_q  <= timer_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      data_q   <= data_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      count_q  <= count_d;
`ifdef FRAME_SEQ_DROP_CNT_EN
      drop_q   <= drop_d;
`endif
    end
  end

  // Frame buffer is deliberately left out of reset.
  always_ff @(posedge clk_in) begin
    if (mem_we) begin
      mem_q[wr_idx_q] <= sample_in;
    end
  end

  assign fft_data_out    = data_q;
  assign fft_valid_out   = valid_q;
  assign fft_last_out    = last_q;
  assign busy_out        = (state_q != IDLE);
  assign frame_done_out  = done_q;
  assign timeout_out     = tmo_q;
  assign frame_count_out = count_q;
`ifdef FRAME_SEQ_DROP_CNT_EN
  assign drop_count_out  = drop_q;
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Testbench for fft_frame_sequencer (FRAME_LEN=16, WIDTH=8, TIMEOUT=20).
// Each frame's expected stream is the queue of samples the bench itself
// offered while capturing; result-wait timing and counters come from the
// frame/peak/timeout rules. Table rows select ready pattern and peak delay.
module tb_fft_frame_sequencer;

  localparam int unsigned FL = 16;
  localparam int unsigned W  = 8;
  localparam int unsigned TO = 20;

  logic         clk = 1'b0;
  logic         rst_n, en, sv, ready, peak;
  logic [W-1:0] sin;
  logic [W-1:0] dout;
  logic         vout, lout, busy, done, tmo;
  logic [15:0]  fcnt;
`ifdef FRAME_SEQ_DROP_CNT_EN
  logic [15:0]  dcnt;
`endif

  always #5 clk = ~clk;

  fft_frame_sequencer #(
    .FRAME_LEN (FL),
    .WIDTH     (W),
    .TIMEOUT   (TO)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .enable_in       (en),
    .sample_in       (sin),
    .sample_valid_in (sv),
    .fft_data_out    (dout),
    .fft_valid_out   (vout),
    .fft_last_out    (lout),
    .fft_ready_in    (ready),
    .peak_valid_in   (peak),
    .busy_out        (busy),
    .frame_done_out  (done),
    .timeout_out     (tmo),
    .frame_count_out (fcnt)
`ifdef FRAME_SEQ_DROP_CNT_EN
    ,
    .drop_count_out  (dcnt)
`endif
  );

  typedef struct {
    int unsigned ready_mode;  // 0 always ready, 1 toggling, 2 random
    int          peak_dly;    // WAIT cycle index at which peak is driven
    bit          exp_done;    // 1 frame_done expected, 0 timeout expected
    int          exp_k;       // pulse visible this many cycles after entry
  } vec_t;

  int tests = 0;
  int fails = 0;
  int unsigned exp_fc   = 0;
  int unsigned exp_drop = 0;
  logic [W-1:0] expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic maybe_drop();
    sv  = ($urandom_range(0, 3) == 0);
    sin = W'($urandom);
    if (sv && exp_drop < 65535) exp_drop++;
  endtask

  // Offers FL samples with random gaps; peak strobes in FILL must be ignored.
  task automatic send_frame();
    for (int i = 0; i < int'(FL); i++) begin
      repeat ($urandom_range(0, 2)) begin
        sv   = 1'b0;
        sin  = W'($urandom);
        peak = ($urandom_range(0, 3) == 0);
        tick();
      end
      sv   = 1'b1;
      sin  = W'($urandom);
      peak = ($urandom_range(0, 3) == 0);
      expq.push_back(sin);
      tick();
    end
    sv   = 1'b0;
    peak = 1'b0;
  endtask

  // Called at the first point after entering STREAM.
  task automatic stream(input int unsigned mode, input int abort_idx, output bit aborted);
    int           xfer = 0;
    int           first_valid = -1;
    bit           pv = 1'b0, pr = 1'b0;
    logic [W-1:0] pd = '0;
    logic         pl = 1'b0;
    aborted = 1'b0;
    ready = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (pv && pr) begin
        chk("xfer_data", dout === dout ? pd : pd, expq[xfer]);
        chk("xfer_last", pl, (xfer == int'(FL) - 1));
        xfer++;
      end else if (pv && !pr) begin
        chk("stall_hold", {vout, lout, dout}, {1'b1, pl, pd});
      end
      if (vout && first_valid < 0) first_valid = cyc;
      if (xfer == int'(FL)) break;
      if (abort_idx >= 0 && xfer == abort_idx) begin
        sv    = 1'b0;
        peak  = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", vout, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", fcnt, 16'd0);
        chk("rst_pulses", {done, tmo, lout}, 3'b000);
`ifdef FRAME_SEQ_DROP_CNT_EN
        chk("rst_drop", dcnt, 16'd0);
`endif
        exp_fc   = 0;
        exp_drop = 0;
        tick();
        tick();
        rst_n = 1'b1;
        expq.delete();
        aborted = 1'b1;
        return;
      end
      pv = vout;
      pd = dout;
      pl = lout;
      case (mode)
        0:       ready = 1'b1;
        1:       ready = ~ready;
        default: ready = 1'(($urandom_range(0, 1)));
      endcase
      pr   = ready;
      peak = ($urandom_range(0, 3) == 0);
      maybe_drop();
      tick();
    end
    chk("xfer_count", xfer, FL);
    chk("valid_latency", (first_valid >= 0 && first_valid <= 2), 1'b1);
    chk("wait_valid_low", vout, 1'b0);
    expq.delete();
  endtask

  // Called at the point where the final transfer was observed (WAIT cycle 0).
  task automatic wait_result(input vec_t v);
    int seen = -1;
    peak = (v.peak_dly == 0);
    maybe_drop();
    for (int k = 1; k <= int'(TO) + 4; k++) begin
      tick();
      peak = 1'b0;
      sv   = 1'b0;
      if (done || tmo) begin
        seen = k;
        break;
      end
      peak = (k == v.peak_dly);
      maybe_drop();
    end
    exp_fc = (exp_fc + 1) & 32'hffff;
    chk("pulse_cycle", seen, v.exp_k);
    chk("frame_done", done, v.exp_done);
    chk("timeout", tmo, !v.exp_done);
    chk("frame_count", fcnt, exp_fc);
    chk("busy_refill", busy, en);
`ifdef FRAME_SEQ_DROP_CNT_EN
    chk("drop_count", dcnt, exp_drop);
`endif
    tick();
    chk("pulse_width", {done, tmo}, 2'b00);
  endtask

  task automatic run_frame(input vec_t v);
    bit ab;
    send_frame();
    stream(v.ready_mode, -1, ab);
    wait_result(v);
  endtask

  vec_t tbl[6];

  initial begin
    bit   ab;
    logic anyv;
    vec_t v;

    tbl[0] = '{ready_mode: 0, peak_dly: 10,  exp_done: 1'b1, exp_k: 11};
    tbl[1] = '{ready_mode: 1, peak_dly: 3,   exp_done: 1'b1, exp_k: 4};
    tbl[2] = '{ready_mode: 2, peak_dly: 0,   exp_done: 1'b1, exp_k: 1};
    tbl[3] = '{ready_mode: 2, peak_dly: 19,  exp_done: 1'b1, exp_k: 20};
    tbl[4] = '{ready_mode: 0, peak_dly: 100, exp_done: 1'b0, exp_k: 20};
    tbl[5] = '{ready_mode: 1, peak_dly: 20,  exp_done: 1'b0, exp_k: 20};

    rst_n = 1'b0; en = 1'b0; sv = 1'b0; sin = '0; ready = 1'b0; peak = 1'b0;
    repeat (3) tick();
    chk("reset_valid", vout, 1'b0);
    chk("reset_last", lout, 1'b0);
    chk("reset_data", dout, '0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_timeout", tmo, 1'b0);
    chk("reset_count", fcnt, 16'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 1'b0);
    peak = 1'b1;
    tick();
    peak = 1'b0;
    tick();
    chk("idle_peak_ignored", {done, fcnt}, 17'd0);

    en = 1'b1;
    tick();
    chk("fill_busy", busy, 1'b1);

    foreach (tbl[i]) run_frame(tbl[i]);

    // Partial frame discarded when enable falls mid-capture.
    for (int i = 0; i < 7; i++) begin
      sv  = 1'b1;
      sin = W'($urandom);
      tick();
    end
    en  = 1'b0;
    sv  = 1'b1;
    sin = W'($urandom);
    tick();
    sv = 1'b0;
    chk("partial_idle", busy, 1'b0);
    anyv = 1'b0;
    repeat (4) begin
      tick();
      anyv |= vout;
    end
    chk("partial_no_stream", anyv, 1'b0);
    en = 1'b1;
    tick();
    v = '{ready_mode: 1, peak_dly: 2, exp_done: 1'b1, exp_k: 3};
    run_frame(v);

    // Reset in the middle of streaming, then a clean frame afterwards.
    send_frame();
    stream(0, 5, ab);
    chk("abort_taken", ab, 1'b1);
    tick();
    v = '{ready_mode: 2, peak_dly: 5, exp_done: 1'b1, exp_k: 6};
    run_frame(v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule

// File: doc/fft_frame_sequencer.md
FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 256, giving samples per FFT frame; legal values are powers of two from 16 to 1024.
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the signed sample width.
REQ-003 The block SHALL have parameter TIMEOUT, default 65535, giving the maximum clk_in cycles to wait for a peak result.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk_in  input  1  system clock (69.632 MHz audio domain).
REQ-006 rst_in  input  1  asynchronous active-low reset.
REQ-007 enable_in  input  1  level; high permits frame capture.
REQ-008 sample_in  input  WIDTH  signed windowed sample.
REQ-009 sample_valid_in  input  1  single-cycle sample strobe.
REQ-010 fft_data_out  output  WIDTH  sample to FFT, AXI-stream data.
REQ-011 fft_valid_out  output  1  AXI-stream valid.
REQ-012 fft_last_out  output  1  high with the final sample of a frame.
REQ-013 fft_ready_in  input  1  AXI-stream ready from FFT.
REQ-014 peak_valid_in  input  1  single-cycle strobe from the peak finder meaning the frame result is done.
REQ-015 busy_out  output  1  high in any state other than IDLE.
REQ-016 frame_done_out  output  1  single-cycle pulse when a frame result is accepted.
REQ-017 timeout_out  output  1  single-cycle pulse when the result wait expires.
REQ-018 frame_count_out  output  16  completed frames, counting both accepted and timed-out frames; wraps from 65535 to 0.

Function
REQ-019 FSM states SHALL be IDLE, FILL, STREAM and WAIT_RESULT.
REQ-020 IDLE->FILL on the first cycle enable_in=1; the write index is cleared to 0.
REQ-021 FILL: each sample_valid_in=1 cycle stores sample_in at the write index and increments it; samples with sample_valid_in=0 are ignored.
REQ-022 FILL->STREAM in the cycle after the FRAME_LEN-th sample is written.
REQ-023 FILL with enable_in=0 SHALL return to IDLE and discard the partial frame; a sample coincident with enable_in falling is discarded.
REQ-024 STREAM: fft_valid_out SHALL assert no later than 2 cycles after entry and present samples in write order, index 0 first.
REQ-025 STREAM: fft_data_out and fft_last_out SHALL hold stable while fft_valid_out=1 and fft_ready_in=0; fft_valid_out SHALL NOT drop without a transfer.
REQ-026 A transfer SHALL occur on each cycle with fft_valid_out=1 and fft_ready_in=1; fft_last_out=1 only on transfer index FRAME_LEN-1.
REQ-027 STREAM SHALL complete the whole frame regardless of enable_in; after the last transfer, go to WAIT_RESULT with fft_valid_out=0 on the next cycle.
REQ-028 sample_valid_in during STREAM or WAIT_RESULT SHALL be dropped; no overlap is supported.
REQ-029 WAIT_RESULT: on peak_valid_in=1, pulse frame_done_out for one cycle and increment frame_count_out.
REQ-030 WAIT_RESULT: after TIMEOUT cycles without peak_valid_in, pulse timeout_out for one cycle and increment frame_count_out.
REQ-031 On leaving WAIT_RESULT, go to FILL if enable_in=1, otherwise IDLE; if peak_valid_in and expiry coincide, the peak wins and no timeout pulse is issued.
REQ-032 peak_valid_in outside WAIT_RESULT SHALL be ignored.

Reset
REQ-033 rst_in=0 SHALL immediately force IDLE, indices 0, all outputs 0 and frame_count_out 0, including mid-STREAM; buffer contents need not be cleared.

Configuration
REQ-034 With FRAME_SEQ_DROP_CNT_EN defined, the block SHALL add output drop_count_out (16, saturating at 65535, reset 0) counting samples dropped under REQ-028; without the macro the port and counter SHALL be absent.

Verification
REQ-035 FRAME_LEN=16, enable=1, samples 0..15, fft_ready_in=1 -> 16 transfers of data 0..15, last on 15, then WAIT_RESULT.
REQ-036 Same, fft_ready_in toggling 1/0 each cycle -> identical data order, data/last stable during stalls, 16 transfers.
REQ-037 peak_valid_in 10 cycles after last -> frame_done_out pulse, frame_count_out=1, back to FILL.
REQ-038 TIMEOUT=20, no peak_valid_in -> timeout_out exactly 20 cycles after WAIT_RESULT entry, frame_count_out=1.
REQ-039 enable_in low after 7 samples -> IDLE, no fft_valid_out; re-enable and 16 new samples -> frame contains only the new samples.
REQ-040 rst_in=0 at transfer 5 -> fft_valid_out=0 immediately, busy_out=0, frame_count_out=0; with the macro, 3 samples during STREAM -> drop_count_out=3.
